// File: rtl/mips_cpu_fetch_if.sv
// Fetch-unit bus: next-PC feedback, decoder handshake and the Avalon-MM
// instruction read master, bundled so the CPU top can pass it as one port.
interface mips_cpu_fetch_if;
    logic [31:0] pcnext_in;
    logic        branch_taken;
    logic        advance;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic [31:0] pc_out;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [3:0]  avm_byteenable;
    logic        active;
    logic        fault;

    // Fetch unit side
    modport master (
        input  pcnext_in, branch_taken, advance, avm_waitrequest, avm_readdata,
        output pc_out, instr, instr_valid, avm_address, avm_read,
               avm_byteenable, active, fault
    );

    // Environment side (next-PC logic, decoder, instruction memory)
    modport slave (
        output pcnext_in, branch_taken, advance, avm_waitrequest, avm_readdata,
        input  pc_out, instr, instr_valid, avm_address, avm_read,
               avm_byteenable, active, fault
    );
endinterface

// File: rtl/mips_cpu_fetch.sv
// MIPS instruction-fetch unit. Holds the architectural PC, reads one word per
// instruction over Avalon-MM, hands it to the decoder, applies the branch
// delay slot and stops the CPU on the halt address or a misaligned target.
module mips_cpu_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter logic [31:0] HALT_ADDR    = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    mips_cpu_fetch_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HOLD   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic        instr_valid_r;
    logic        avm_read_r;
    logic        active_r;
    logic        fault_r;
    logic        delay_pending_r;
    logic [31:0] delay_target_r;

    logic [31:0] new_pc_s;
    logic        halt_hit_s;
    logic        misalign_s;

    // Address taken on advance: a pending branch target wins over pc+4; the
    // branch instruction itself always proceeds to its delay slot.
    always_comb begin
        new_pc_s   = pc_r + 32'd4;
        halt_hit_s = 1'b0;
        misalign_s = 1'b0;
        if (delay_pending_r) begin
            new_pc_s = delay_target_r;
        end else begin
            new_pc_s = pc_r + 32'd4;
        end
        halt_hit_s = (new_pc_s == HALT_ADDR);
        misalign_s = (new_pc_s[1:0] != 2'b00);
    end

    // Fetch state machine; every bus-facing output is a register so avm_read
    // has no combinational path from waitrequest and drops at once on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            pc_r            <= RESET_VECTOR;
            instr_r         <= 32'h0000_0000;
            instr_valid_r   <= 1'b0;
            avm_read_r      <= 1'b0;
            active_r        <= 1'b0;
            fault_r         <= 1'b0;
            delay_pending_r <= 1'b0;
            delay_target_r  <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r    <= ST_FETCH;
                    active_r   <= 1'b1;
                    avm_read_r <= 1'b1;
                end
                ST_FETCH: begin
                    if (!bus.avm_waitrequest) begin
                        instr_r       <= bus.avm_readdata;
                        instr_valid_r <= 1'b1;
                        avm_read_r    <= 1'b0;
                        state_r       <= ST_HOLD;
                    end else begin
                        avm_read_r    <= 1'b1;
                        state_r       <= ST_FETCH;
                    end
                end
                ST_HOLD: begin
                    if (bus.advance) begin
                        pc_r          <= new_pc_s;
                        instr_valid_r <= 1'b0;
                        // Branches inside a delay slot are not architecturally visible.
                        if (delay_pending_r) begin
                            delay_pending_r <= 1'b0;
                        end else if (bus.branch_taken) begin
                            delay_target_r  <= bus.pcnext_in;
                            delay_pending_r <= 1'b1;
                        end else begin
                            delay_pending_r <= 1'b0;
                        end
                        if (halt_hit_s) begin
                            state_r  <= ST_HALTED;
                            active_r <= 1'b0;
                        end else if (misalign_s) begin
                            state_r  <= ST_HALTED;
                            active_r <= 1'b0;
                            fault_r  <= 1'b1;
                        end else begin
                            state_r    <= ST_FETCH;
                            avm_read_r <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                ST_HALTED: begin
                    state_r       <= ST_HALTED;
                    active_r      <= 1'b0;
                    avm_read_r    <= 1'b0;
                    instr_valid_r <= 1'b0;
                end
                default: begin
                    state_r       <= ST_HALTED;
                    active_r      <= 1'b0;
                    avm_read_r    <= 1'b0;
                    instr_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_out         = pc_r;
    assign bus.avm_address    = pc_r;
    assign bus.avm_read       = avm_read_r;
    assign bus.avm_byteenable = 4'hF;
    assign bus.instr          = instr_r;
    assign bus.instr_valid    = instr_valid_r;
    assign bus.active         = active_r;
    assign bus.fault          = fault_r;

endmodule

// File: tb/tb_mips_cpu_fetch.sv
// Directed bench for mips_cpu_fetch: a per-cycle vector table for the main
// fetch/branch/halt flow plus hand sequences for misalignment, reset during
// a stalled read and PC wrap-around.
module tb_mips_cpu_fetch;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mips_cpu_fetch_if bus ();

    mips_cpu_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Instruction memory model: word = inverted address; garbage while stalled.
    assign bus.avm_readdata = bus.avm_waitrequest ? 32'hDEAD_BEEF : ~bus.avm_address;

    typedef struct {
        logic        adv;
        logic        br;
        logic [31:0] nxt;
        logic        wr;
        logic [31:0] pc;
        logic        rd;
        logic        vld;
        logic        act;
        logic        flt;
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t mk(input logic adv, input logic br, input logic [31:0] nxt,
                                input logic wr, input logic [31:0] pc, input logic rd,
                                input logic vld, input logic act, input logic flt);
        vec_t v;
        v.adv = adv; v.br = br; v.nxt = nxt; v.wr = wr;
        v.pc = pc; v.rd = rd; v.vld = vld; v.act = act; v.flt = flt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic adv, input logic br, input logic [31:0] nxt, input logic wr);
        bus.advance         = adv;
        bus.branch_taken    = br;
        bus.pcnext_in       = nxt;
        bus.avm_waitrequest = wr;
    endtask

    task automatic step(input logic adv, input logic br, input logic [31:0] nxt, input logic wr);
        drive(adv, br, nxt, wr);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pc, input logic rd,
                             input logic vld, input logic act, input logic flt);
        chk({tag, ".pc_out"},      bus.pc_out,               pc);
        chk({tag, ".avm_address"}, bus.avm_address,          pc);
        chk({tag, ".avm_read"},    {31'd0, bus.avm_read},    {31'd0, rd});
        chk({tag, ".instr_valid"}, {31'd0, bus.instr_valid}, {31'd0, vld});
        chk({tag, ".active"},      {31'd0, bus.active},      {31'd0, act});
        chk({tag, ".fault"},       {31'd0, bus.fault},       {31'd0, flt});
        if (vld) begin
            chk({tag, ".instr"}, bus.instr, ~pc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0000_0000, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // Main flow: advance held high, fetches 00/04/08 (08 stalled 3 cycles),
        // 0C, 10 branch -> 14 delay slot -> 100, JR 0 from 100 -> 104 slot -> halt.
        tbl[0]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'hBFC0_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        tbl[1]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'hBFC0_0000, 1'b0, 1'b1, 1'b1, 1'b0);
        tbl[2]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'hBFC0_0004, 1'b1, 1'b0, 1'b1, 1'b0);
        tbl[3]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'hBFC0_0004, 1'b0, 1'b1, 1'b1, 1'b0);
        tbl[4]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'hBFC0_0008, 1'b1, 1'b0, 1'b1, 1'b0);
        tbl[5]  = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'hBFC0_0008, 1'b1, 1'b0, 1'b1, 1'b0);
        tbl[6]  = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'hBFC0_0008, 1'b1, 1'b0, 1'b1, 1'b0);
        tbl[7]  = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'hBFC0_0008, 1'b1, 1'b0, 1'b1, 1'b0);
        tbl[8]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'hBFC0_0008, 1'b0, 1'b1, 1'b1, 1'b0);
        tbl[9]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'hBFC0_000C, 1'b1, 1'b0, 1'b1, 1'b0);
        tbl[10] = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'hBFC0_000C, 1'b0, 1'b1, 1'b1, 1'b0);
        tbl[11] = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'hBFC0_0010, 1'b1, 1'b0, 1'b1, 1'b0);
        tbl[12] = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'hBFC0_0010, 1'b0, 1'b1, 1'b1, 1'b0);
        tbl[13] = mk(1'b1, 1'b1, 32'hBFC0_0100, 1'b0, 32'hBFC0_0014, 1'b1, 1'b0, 1'b1, 1'b0);
        tbl[14] = mk(1'b1, 1'b1, 32'hBFC0_0200, 1'b0, 32'hBFC0_0014, 1'b0, 1'b1, 1'b1, 1'b0);
        tbl[15] = mk(1'b1, 1'b1, 32'hBFC0_0200, 1'b0, 32'hBFC0_0100, 1'b1, 1'b0, 1'b1, 1'b0);
        tbl[16] = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'hBFC0_0100, 1'b0, 1'b1, 1'b1, 1'b0);
        tbl[17] = mk(1'b1, 1'b1, 32'h0,         1'b0, 32'hBFC0_0104, 1'b1, 1'b0, 1'b1, 1'b0);
        tbl[18] = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'hBFC0_0104, 1'b0, 1'b1, 1'b1, 1'b0);
        tbl[19] = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[20] = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[21] = mk(1'b1, 1'b1, 32'hBFC0_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);

        drive(1'b1, 1'b0, 32'h0000_0000, 1'b0);
        #12;
        chk_state("reset", 32'hBFC0_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.instr", bus.instr, 32'h0000_0000);
        chk("byteenable", {28'd0, bus.avm_byteenable}, 32'h0000_000F);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].adv, tbl[i].br, tbl[i].nxt, tbl[i].wr);
            chk_state($sformatf("vec%0d", i), tbl[i].pc, tbl[i].rd, tbl[i].vld,
                      tbl[i].act, tbl[i].flt);
        end

        // Misaligned target: delay slot runs, then halt with fault, no read.
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'hBFC0_0102, 1'b0);
        chk_state("mis.slot", 32'hBFC0_0004, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk_state("mis.halt", 32'hBFC0_0102, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk_state("mis.stay", 32'hBFC0_0102, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset during a stalled read with a branch pending.
        do_reset();
        chk("rst.fault_clear", {31'd0, bus.fault}, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'hBFC0_0300, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk_state("rst.stall", 32'hBFC0_0004, 1'b1, 1'b0, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_state("rst.async", 32'hBFC0_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk_state("rst.refetch", 32'hBFC0_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk_state("rst.nopend", 32'hBFC0_0004, 1'b1, 1'b0, 1'b1, 1'b0);

        // pc+4 wraps from FFFFFFFC to 0 and halts without fault.
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk_state("wrap.top", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk_state("wrap.hold", 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk_state("wrap.halt", 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_cpu_fetch.md
# mips_cpu_fetch

Instruction-fetch unit: holds the architectural PC, feeds it to the next-PC logic, and consumes the resulting next address. Issues word reads to instruction memory over an Avalon-MM read master, presents each fetched instruction to the decoder, and applies the MIPS branch delay slot. Halts the CPU when execution reaches the halt address.

## Interface
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset
- HALT_ADDR, 32'h00000000, fetch address that stops the CPU instead of being read
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-high reset
- pcnext_in  input  32  next address computed for the instruction at pc_out
- branch_taken  input  1  pcnext_in is a non-sequential target (branch taken, J, JAL, JR, JALR); sampled only with advance
- advance  input  1  decoder/execute has consumed the current instruction; meaningful only while instr_valid=1
- avm_waitrequest  input  1  memory not ready; read held
- avm_readdata  input  32  instruction word, valid in a cycle with avm_read=1 and avm_waitrequest=0
- pc_out  output  32  address of the current instruction (drives the next-PC block and link computation)
- instr  output  32  registered instruction word
- instr_valid  output  1  instr holds the instruction at pc_out
- avm_address  output  32  equals pc_out
- avm_read  output  1  read request
- avm_byteenable  output  4  constant 4'hF
- active  output  1  CPU running
- fault  output  1  sticky; misaligned fetch address detected

## Operation
- States: IDLE, FETCH, HOLD, HALTED.
- IDLE: entered on reset; next cycle -> FETCH, active<=1.
- FETCH: avm_read=1, avm_address=pc_out. Cycle with avm_waitrequest=0: instr<=avm_readdata, instr_valid<=1, -> HOLD. While avm_waitrequest=1, address and read stay stable.
- HOLD: instr_valid=1, avm_read=0. On advance:
  - delay_pending=1: pc<=delay_target, delay_pending<=0; branch_taken in the delay slot is ignored.
  - else if branch_taken: delay_target<=pcnext_in, delay_pending<=1, pc<=pc_out+4 (delay slot fetched next).
  - else pc<=pc_out+4.
  - instr_valid<=0. Next state chosen from the new pc: equals HALT_ADDR -> HALTED; pc[1:0]!=0 -> HALTED with fault<=1; otherwise FETCH.
- HALTED: terminal until reset. active=0, avm_read=0, instr_valid=0, pc_out frozen at the halting address.
- Arithmetic: pc+4 is 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0 and therefore halts.
- Jump to HALT_ADDR: the delay-slot instruction is fetched and executed first, then the CPU halts.

## Timing
- Reset values: pc_out=RESET_VECTOR, instr=0, instr_valid=0, avm_read=0, active=0, fault=0, delay_pending=0, state IDLE.
- Reset is asynchronous. Asserting it mid-read drops avm_read immediately. A completing read in that cycle is discarded.
- avm_read is a registered/state-decoded output with no combinational path from avm_waitrequest.
- First avm_read=1: second rising edge after reset deasserts (IDLE, then FETCH).
- Zero-wait memory: FETCH 1 cycle, then HOLD at least 1 cycle. Minimum 2 cycles per instruction.
- Each additional waitrequest cycle adds one cycle.
- advance while not in HOLD is ignored.
- advance in the same cycle as HOLD entry is not possible, because instr_valid is registered.

## Test plan
- Reset release, memory with zero wait states, advance held high -> first avm_address=BFC00000 with avm_read=1 on the 2nd edge. Subsequent reads at BFC00004, BFC00008, each 2 cycles apart.
- Read with avm_waitrequest high for 3 cycles -> avm_address and avm_read stable for 4 cycles. instr captures the word from the cycle where waitrequest=0.
- Instruction at BFC00010 advances with branch_taken=1, pcnext_in=BFC00100 -> next fetch BFC00014 (delay slot), then BFC00100. branch_taken=1 in the delay slot has no effect.
- JR to 00000000 (branch_taken=1, pcnext_in=0) -> delay slot fetched. After its advance: pc_out=0, active=0, no further avm_read.
- Target BFC00102 -> after the delay slot: HALTED, fault=1, active=0, no read issued at the misaligned address.
- reset asserted during FETCH with waitrequest=1 -> avm_read=0 in the same cycle. After release, fetch restarts at BFC00000 with delay_pending cleared.
